// File: rtl/ccd_seq_pkg.sv
// Shared types and default sizing for the CCD clock sequencer.
package ccd_seq_pkg;
  localparam int HALF_W_DEF = 4;
  localparam int PIX_W_DEF  = 11;
  localparam int LINE_W_DEF = 11;
  localparam int PTX_W_DEF  = 8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_VXFER = 2'd1,
    ST_HREAD = 2'd2,
    ST_FEND  = 2'd3
  } ccd_state_e;
endpackage

// File: rtl/ccd_pixel_phase.sv
// Pixel phase counter: generates the horizontal clocks, reset gate and ADC strobe.
module ccd_pixel_phase #(
  parameter int HALF_W = 4
) (
  input  logic              clk_i,
  input  logic              rst_n_i,
  input  logic              en_i,
  input  logic              act_i,
  input  logic              hold_i,
  input  logic [HALF_W-1:0] half_i,
  input  logic [HALF_W-1:0] rst_i,
  output logic              phi_l1_o,
  output logic              phi_l2_o,
  output logic              phi_r_o,
  output logic              sample_o,
  output logic              wrap_o
);
  localparam int PH_W = HALF_W + 1;

  logic [PH_W-1:0] ph_q, ph_d, last;
  logic            l1_q, l2_q, r_q, smp_q;

  assign last   = {half_i, 1'b0} - PH_W'(1);
  assign wrap_o = en_i && (ph_q == last);
  // Phase restarts at 0 whenever HREAD is (re)entered or a pixel wraps.
  assign ph_d   = (act_i && en_i && !wrap_o) ? ph_q + PH_W'(1) : '0;

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      ph_q  <= '0;
      l1_q  <= 1'b0;
      l2_q  <= 1'b0;
      r_q   <= 1'b0;
      smp_q <= 1'b0;
    end else begin
      ph_q  <= ph_d;
      l2_q  <= hold_i | (act_i && (ph_d < PH_W'(half_i)));
      l1_q  <= act_i && (ph_d >= PH_W'(half_i));
      r_q   <= act_i && (ph_d < PH_W'(rst_i));
      smp_q <= act_i && (ph_d == last);
    end
  end

  assign phi_l1_o = l1_q;
  assign phi_l2_o = l2_q;
  assign phi_r_o  = r_q;
  assign sample_o = smp_q;
endmodule

// File: rtl/ccd_clock_sequencer.sv
// CCD readout clock sequencer: vertical transfer, per-pixel horizontal clocking, frame control.
module ccd_clock_sequencer
  import ccd_seq_pkg::*;
#(
  parameter int HALF_W = HALF_W_DEF,
  parameter int PIX_W  = PIX_W_DEF,
  parameter int LINE_W = LINE_W_DEF,
  parameter int PTX_W  = PTX_W_DEF
) (
  input  logic              clk_i,
  input  logic              rst_n_i,
  input  logic              start_i,
  input  logic              stop_i,
  input  logic              cont_i,
  input  logic [HALF_W-1:0] cfg_half_i,
  input  logic [HALF_W-1:0] cfg_rst_i,
  input  logic [PIX_W-1:0]  cfg_pixels_i,
  input  logic [LINE_W-1:0] cfg_lines_i,
  input  logic [PTX_W-1:0]  cfg_ptx_i,
  output logic              phi_p_o,
  output logic              phi_l1_o,
  output logic              phi_l2_o,
  output logic              phi_r_o,
  output logic              sample_o,
  output logic              busy_o,
  output logic              line_done_o,
  output logic              frame_done_o,
  output logic              cfg_err_o,
  output logic [PIX_W-1:0]  pix_idx_o,
  output logic [LINE_W-1:0] line_idx_o
);
  ccd_state_e        state_q, state_d;
  logic [HALF_W-1:0] half_q, rst_q, half_eff, rst_eff;
  logic [PIX_W-1:0]  npix_q, pix_q, pix_d;
  logic [LINE_W-1:0] nline_q, line_q, line_d;
  logic [PTX_W-1:0]  ptx_q, ptx_cnt_q, ptx_cnt_d, ptx_eff;
  logic              cont_q, stop_seen_q, stop_seen_d;
  logic              phi_p_q, busy_q, line_done_q, frame_done_q, cfg_err_q;
  logic              latch, line_done_d, cfg_err_d, abort, wrap;
  logic              pix_last, line_last, ptx_last;

  assign half_eff = (cfg_half_i == '0) ? HALF_W'(1) : cfg_half_i;
  assign rst_eff  = (cfg_rst_i > half_eff) ? half_eff : cfg_rst_i;
  assign ptx_eff  = (cfg_ptx_i == '0) ? PTX_W'(1) : cfg_ptx_i;

  // Widened compares so counters can never wrap at full-scale config.
  assign pix_last  = ({1'b0, pix_q} + (PIX_W+1)'(1)) == {1'b0, npix_q};
  assign line_last = ({1'b0, line_q} + (LINE_W+1)'(1)) == {1'b0, nline_q};
  assign ptx_last  = ({1'b0, ptx_cnt_q} + (PTX_W+1)'(1)) == {1'b0, ptx_q};
  assign abort     = stop_i && !cont_q && (state_q == ST_VXFER || state_q == ST_HREAD);

  always_comb begin
    state_d     = state_q;
    pix_d       = pix_q;
    line_d      = line_q;
    ptx_cnt_d   = ptx_cnt_q;
    stop_seen_d = stop_seen_q | (stop_i && state_q != ST_IDLE);
    latch       = 1'b0;
    line_done_d = 1'b0;
    cfg_err_d   = 1'b0;
    unique case (state_q)
      ST_IDLE: if (start_i) begin
        if (cfg_pixels_i == '0 || cfg_lines_i == '0) cfg_err_d = 1'b1;
        else begin
          latch       = 1'b1;
          state_d     = ST_VXFER;
          pix_d       = '0;
          line_d      = '0;
          ptx_cnt_d   = '0;
          stop_seen_d = 1'b0;
        end
      end
      ST_VXFER: begin
        if (abort) state_d = ST_IDLE;
        else if (ptx_last) begin
          state_d   = ST_HREAD;
          ptx_cnt_d = '0;
        end else ptx_cnt_d = ptx_cnt_q + PTX_W'(1);
      end
      ST_HREAD: begin
        if (abort) state_d = ST_IDLE;
        else if (wrap) begin
          if (pix_last) begin
            pix_d       = '0;
            line_d      = line_q + LINE_W'(1);
            line_done_d = 1'b1;
            state_d     = line_last ? ST_FEND : ST_VXFER;
          end else pix_d = pix_q + PIX_W'(1);
        end
      end
      ST_FEND: begin
        if (cont_q && !stop_seen_d) begin
          state_d = ST_VXFER;
          line_d  = '0;
        end else state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      state_q      <= ST_IDLE;
      pix_q        <= '0;
      line_q       <= '0;
      ptx_cnt_q    <= '0;
      stop_seen_q  <= 1'b0;
      half_q       <= '0;
      rst_q        <= '0;
      npix_q       <= '0;
      nline_q      <= '0;
      ptx_q        <= '0;
      cont_q       <= 1'b0;
      phi_p_q      <= 1'b0;
      busy_q       <= 1'b0;
      line_done_q  <= 1'b0;
      frame_done_q <= 1'b0;
      cfg_err_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      pix_q        <= pix_d;
      line_q       <= line_d;
      ptx_cnt_q    <= ptx_cnt_d;
      stop_seen_q  <= stop_seen_d;
      if (latch) begin
        half_q  <= half_eff;
        rst_q   <= rst_eff;
        npix_q  <= cfg_pixels_i;
        nline_q <= cfg_lines_i;
        ptx_q   <= ptx_eff;
        cont_q  <= cont_i;
      end
      phi_p_q      <= state_d == ST_VXFER;
      busy_q       <= state_d != ST_IDLE;
      line_done_q  <= line_done_d;
      frame_done_q <= state_d == ST_FEND;
      cfg_err_q    <= cfg_err_d;
    end
  end

  ccd_pixel_phase #(.HALF_W(HALF_W)) u_phase (
    .clk_i    (clk_i),
    .rst_n_i  (rst_n_i),
    .en_i     (state_q == ST_HREAD),
    .act_i    (state_d == ST_HREAD),
    .hold_i   (state_d == ST_VXFER),
    .half_i   (half_q),
    .rst_i    (rst_q),
    .phi_l1_o (phi_l1_o),
    .phi_l2_o (phi_l2_o),
    .phi_r_o  (phi_r_o),
    .sample_o (sample_o),
    .wrap_o   (wrap)
  );

  assign phi_p_o      = phi_p_q;
  assign busy_o       = busy_q;
  assign line_done_o  = line_done_q;
  assign frame_done_o = frame_done_q;
  assign cfg_err_o    = cfg_err_q;
  assign pix_idx_o    = pix_q;
  assign line_idx_o   = line_q;
endmodule
